imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the next-generation core. It replaces the combinational ImmGen between decode and execute. The block accepts instruction bits [31:7] plus a format select under a valid/ready handshake and produces an XLEN-wide extended immediate one cycle later. A 2-entry skid buffer provides full throughput, a flag marks illegal selects, and a saturating counter counts them.

---
 rtl/imm_pkg.sv | 31 +++
 rtl/imm_decode.sv | 51 +++++
 rtl/imm_gen_pipe.sv | 130 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// ============================================================================
// Module : imm_pkg
// Brief  : Immediate format selects and XLEN legality helper for imm_gen_pipe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imm_pkg;

    localparam int unsigned C_INST_W = 25;
    localparam int unsigned C_SEL_W  = 3;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_sel_e;

    localparam int unsigned C_XLEN_32 = 32;
    localparam int unsigned C_XLEN_64 = 64;

    function automatic bit imm_xlen_legal(input int unsigned xlen);
        return (xlen == C_XLEN_32) || (xlen == C_XLEN_64);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// Module : imm_decode
// Brief  : Combinational RISC-V immediate extraction and extension to XLEN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [C_INST_W-1:0] inst,
    input  logic [C_SEL_W-1:0]  sel,
    output logic [XLEN-1:0]     imm,
    output logic                err
);

    // inst[k] carries instr[k+7]; fields below are named in instruction bit terms.
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;
    logic        [4:0]  w_zimm;

    assign w_imm_i = inst[24:13];
    assign w_imm_s = {inst[24:18], inst[4:0]};
    assign w_imm_b = {inst[24], inst[0], inst[23:18], inst[4:1], 1'b0};
    assign w_imm_u = {inst[24:5], 12'b0};
    assign w_imm_j = {inst[24], inst[12:5], inst[13], inst[23:14], 1'b0};
    assign w_zimm  = inst[12:8];

    // Signed sources widen with sign extension; zimm is unsigned and zero-extends.
    always_comb begin
        imm = '0;
        err = 1'b0;
        case (sel)
            IMM_I:   imm = XLEN'(w_imm_i);
            IMM_S:   imm = XLEN'(w_imm_s);
            IMM_B:   imm = XLEN'(w_imm_b);
            IMM_U:   imm = XLEN'(w_imm_u);
            IMM_J:   imm = XLEN'(w_imm_j);
            IMM_Z:   imm = XLEN'(w_zimm);
            default: err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module : imm_gen_pipe
// Brief  : Pipelined immediate generator with 2-entry skid buffer and
//          saturating illegal-select counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TAG_W     = 5,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [C_INST_W-1:0]  in_inst,
    input  logic [C_SEL_W-1:0]   in_sel,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic                 out_err,
    output logic [TAG_W-1:0]     out_tag,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 cnt_clr
);

    generate
        if (!imm_xlen_legal(XLEN)) begin : g_xlen_illegal
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [ERR_CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] C_CNT_ONE = ERR_CNT_W'(1);

    logic [XLEN-1:0]      w_dec_imm;
    logic                 w_dec_err;
    logic                 w_accept;
    logic                 w_out_free;

    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [XLEN-1:0]      r_out_imm;
    logic                 r_out_err;
    logic [TAG_W-1:0]     r_out_tag;
    logic                 r_skid_full;
    logic [XLEN-1:0]      r_skid_imm;
    logic                 r_skid_err;
    logic [TAG_W-1:0]     r_skid_tag;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst (in_inst),
        .sel  (in_sel),
        .imm  (w_dec_imm),
        .err  (w_dec_err)
    );

    assign w_accept   = in_valid && r_in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    // r_in_ready mirrors !r_skid_full so the upstream sees a flop, not logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_imm   <= '0;
            r_out_err   <= 1'b0;
            r_out_tag   <= '0;
            r_skid_full <= 1'b0;
            r_skid_imm  <= '0;
            r_skid_err  <= 1'b0;
            r_skid_tag  <= '0;
        end else if (w_out_free) begin
            if (r_skid_full) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= r_skid_imm;
                r_out_err   <= r_skid_err;
                r_out_tag   <= r_skid_tag;
                r_skid_full <= 1'b0;
                r_in_ready  <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_dec_imm;
                r_out_err   <= w_dec_err;
                r_out_tag   <= in_tag;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_full <= 1'b1;
            r_skid_imm  <= w_dec_imm;
            r_skid_err  <= w_dec_err;
            r_skid_tag  <= in_tag;
            r_in_ready  <= 1'b0;
        end
    end

    // A clear coinciding with an illegal accept counts that accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_dec_err) begin
            if (cnt_clr) begin
                r_err_cnt <= C_CNT_ONE;
            end else if (r_err_cnt != C_CNT_MAX) begin
                r_err_cnt <= r_err_cnt + C_CNT_ONE;
            end
        end else if (cnt_clr) begin
            r_err_cnt <= '0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_imm   = r_out_imm;
    assign out_err   = r_out_err;
    assign out_tag   = r_out_tag;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module : tb_imm_gen_pipe
// Brief  : Self-checking bench for imm_gen_pipe (XLEN=32 plus an XLEN=64 twin).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    localparam int TAG_W = 5;
    localparam int CW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_inst;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_imm;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;
    logic [CW-1:0]    err_cnt;
    logic             cnt_clr;

    logic             o64_in_ready;
    logic             o64_valid;
    logic [63:0]      o64_imm;
    logic             o64_err;
    logic [TAG_W-1:0] o64_tag;
    logic [CW-1:0]    o64_cnt;

    imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W), .ERR_CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_err(out_err), .out_tag(out_tag), .err_cnt(err_cnt), .cnt_clr(cnt_clr)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W), .ERR_CNT_W(CW)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o64_in_ready),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(o64_valid), .out_ready(out_ready), .out_imm(o64_imm),
        .out_err(o64_err), .out_tag(o64_tag), .err_cnt(o64_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: rebuild the full instruction word and apply the format rules.
    function automatic logic [64:0] ref_model(input logic [24:0] inst, input logic [2:0] sel);
        logic [31:0] ins;
        longint      v;
        logic        e;
        ins = {inst, 7'b0};
        e   = 1'b0;
        v   = 0;
        case (sel)
            3'd0: v = longint'($signed(ins[31:20]));
            3'd1: v = longint'($signed({ins[31:25], ins[11:7]}));
            3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: v = longint'($signed({ins[31:12], 12'b0}));
            3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd5: v = longint'(ins[19:15]);
            default: e = 1'b1;
        endcase
        return {e, 64'(v)};
    endfunction

    typedef struct {
        logic [31:0]      imm;
        logic             err;
        logic [TAG_W-1:0] tag;
    } sb_t;

    sb_t sb[$];
    int  m_cnt = 0;

    // Scoreboard: occupancy drives expected valid/ready, head must match while valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            logic [64:0] r;
            check("mon_out_valid", 64'(out_valid), 64'(sb.size() != 0));
            check("mon_in_ready", 64'(in_ready), 64'(sb.size() < 2));
            check("mon_err_cnt", 64'(err_cnt), 64'(m_cnt));
            if (out_valid && sb.size() != 0) begin
                check("mon_out_imm", 64'(out_imm), 64'(sb[0].imm));
                check("mon_out_err", 64'(out_err), 64'(sb[0].err));
                check("mon_out_tag", 64'(out_tag), 64'(sb[0].tag));
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                r = ref_model(in_inst, in_sel);
                sb.push_back('{imm: r[31:0], err: r[64], tag: in_tag});
                if (r[64]) m_cnt = cnt_clr ? 1 : ((m_cnt == 255) ? 255 : m_cnt + 1);
                else if (cnt_clr) m_cnt = 0;
            end else if (cnt_clr) begin
                m_cnt = 0;
            end
        end
    end

    typedef struct {
        logic [24:0] inst;
        logic [2:0]  sel;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{25'h1D4A000, 3'd0, 32'hFFFFFEA5, 64'hFFFFFFFFFFFFFEA5, 1'b0};
        tbl[1]  = '{25'h0FFFFFF, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        tbl[2]  = '{25'h0D4A005, 3'd1, 32'h000006A5, 64'h00000000000006A5, 1'b0};
        tbl[3]  = '{25'h1000001, 3'd1, 32'hFFFFF801, 64'hFFFFFFFFFFFFF801, 1'b0};
        tbl[4]  = '{25'h1000015, 3'd2, 32'hFFFFF814, 64'hFFFFFFFFFFFFF814, 1'b0};
        tbl[5]  = '{25'h02468A0, 3'd3, 32'h12345000, 64'h0000000012345000, 1'b0};
        tbl[6]  = '{25'h1000000, 3'd3, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        tbl[7]  = '{25'h0557560, 3'd4, 32'h000ABAAA, 64'h00000000000ABAAA, 1'b0};
        tbl[8]  = '{25'h1000000, 3'd4, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        tbl[9]  = '{25'h1001401, 3'd5, 32'h00000014, 64'h0000000000000014, 1'b0};
        tbl[10] = '{25'h1FFFFFF, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1};
        tbl[11] = '{25'h1FFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};

        rst_n = 1'b1; in_valid = 1'b0; in_inst = '0; in_sel = '0; in_tag = '0;
        out_ready = 1'b0; cnt_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_out_imm", 64'(out_imm), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Table vectors streamed back to back with out_ready high.
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_inst = tbl[i].inst; in_sel = tbl[i].sel; in_tag = TAG_W'(i);
            @(posedge clk); #1;
            check("tbl_valid", 64'(out_valid), 64'd1);
            check("tbl_imm32", 64'(out_imm), 64'(tbl[i].exp32));
            check("tbl_imm64", o64_imm, tbl[i].exp64);
            check("tbl_err", 64'(out_err), 64'(tbl[i].err));
            check("tbl_tag", 64'(out_tag), 64'(i));
            check("tbl_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("drain_valid", 64'(out_valid), 64'd0);

        // Stall: three beats offered with out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1; in_sel = 3'd0; in_inst = 25'h0002000; in_tag = 5'd1;
        @(posedge clk); #1;
        check("stall_a_valid", 64'(out_valid), 64'd1);
        check("stall_ready1", 64'(in_ready), 64'd1);
        in_inst = 25'h0004000; in_tag = 5'd2;
        @(posedge clk); #1;
        check("stall_ready2", 64'(in_ready), 64'd0);
        in_inst = 25'h0006000; in_tag = 5'd3;
        @(posedge clk); #1;
        check("stall_hold_imm", 64'(out_imm), 64'd1);
        check("stall_hold_tag", 64'(out_tag), 64'd1);
        check("stall_ready3", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("rel_tag_b", 64'(out_tag), 64'd2);
        check("rel_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        check("rel_tag_c", 64'(out_tag), 64'd3);
        check("rel_imm_c", 64'(out_imm), 64'd3);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rel_empty", 64'(out_valid), 64'd0);

        // Saturation: 300 illegal beats, then clear coinciding with an illegal accept.
        in_valid = 1'b1; in_sel = 3'd6; in_inst = 25'h1ABCDEF; in_tag = 5'd7;
        repeat (300) @(posedge clk);
        #1;
        check("sat_out_err", 64'(out_err), 64'd1);
        check("sat_out_imm", 64'(out_imm), 64'd0);
        check("sat_cnt", 64'(err_cnt), 64'd255);
        in_sel = 3'd7; cnt_clr = 1'b1;
        @(posedge clk); #1;
        check("clr_with_err", 64'(err_cnt), 64'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_alone", 64'(err_cnt), 64'd0);
        cnt_clr = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset with both registers holding illegal beats.
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd6;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_ready", 64'(in_ready), 64'd0);
        check("pre_rst_cnt", 64'(err_cnt), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_ready", 64'(in_ready), 64'd1);
        check("async_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd5; in_inst = 25'h0000900; in_tag = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_rst_tag", 64'(out_tag), 64'd9);
        check("post_rst_imm", 64'(out_imm), 64'd9);
        @(posedge clk); #1;
        check("post_rst_empty", 64'(out_valid), 64'd0);

        // Random traffic against the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_inst   = 25'($urandom);
            in_sel    = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
